// File: rtl/uart_tx_sched_pkg.sv
// Shared FSM state encoding and UART register map for the TX scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCfgBrg,
    StCfgCtl,
    StReady,
    StSend,
    StWait,
    StCfgOff
  } state_e;

  localparam logic [1:0]  AddrBrg    = 2'd0;
  localparam logic [1:0]  AddrCtl    = 2'd1;
  localparam logic [1:0]  AddrTxr    = 2'd2;

  localparam logic [15:0] CtlEnable  = 16'h0001;
  localparam logic [15:0] CtlDisable = 16'h0000;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester byte stream plus UART register bus; the scheduler is the master,
// the requester/UART side is the slave.
interface uart_tx_sched_if;

  logic        inValid;
  logic [7:0]  inData;
  logic        inReady;
  logic        busEn;
  logic        busWr;
  logic [1:0]  busAddr;
  logic [15:0] busWrData;
  logic        sigTxInt;

  modport master (
    input  inValid, inData, sigTxInt,
    output inReady, busEn, busWr, busAddr, busWrData
  );

  modport slave (
    output inValid, inData, sigTxInt,
    input  inReady, busEn, busWr, busAddr, busWrData
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// DEPTH x 8 byte FIFO with synchronous flush; pointers wrap modulo DEPTH,
// so DEPTH must be a power of two.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [7:0]    data_i,
  output logic [7:0]    head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic          doPush;
  logic          doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Flush wins over push/pop so a stop always leaves the FIFO empty.
  always_ff @(posedge clk) begin
    if (!rstn || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Configures a UART and feeds it queued bytes one at a time, waiting for each
// TX-done pulse. Optional WAIT watchdog: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 720896
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [15:0]            cfgBaud,
  input  logic                   cfgStart,
  input  logic                   cfgStop,
  uart_tx_sched_if.master        bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifoCount,
  output logic                   errTimeout
);

  state_e      state_q;
  logic        stopPend_q;
  logic        busEn_q;
  logic [1:0]  busAddr_q;
  logic [15:0] busWrData_q;

  logic        fifoPush;
  logic        fifoPop;
  logic        fifoFlush;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [7:0]  fifoHead;

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam logic [23:0] TimeoutLast = 24'(TIMEOUT - 1);
  logic [23:0] timer_q;
  logic        errTimeout_q;
  assign errTimeout = errTimeout_q;
`else
  assign errTimeout = 1'b0;
`endif

  // Gated by rstn so the requester sees no room while reset is held.
  assign bus.inReady   = rstn & ~fifoFull & (state_q != StCfgOff);
  assign fifoPush      = bus.inValid & bus.inReady;
  assign fifoPop       = (state_q == StSend);
  assign fifoFlush     = (state_q == StCfgOff);

  assign bus.busEn     = busEn_q;
  assign bus.busWr     = busEn_q;
  assign bus.busAddr   = busAddr_q;
  assign bus.busWrData = busWrData_q;

  assign busy = ((state_q != StIdle) && (state_q != StReady)) || !fifoEmpty;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .flush_i (fifoFlush),
    .data_i  (bus.inData),
    .head_o  (fifoHead),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Bus outputs are loaded on entry to the state that owns the write, so they
  // line up with that state for exactly one cycle and idle at zero otherwise.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      stopPend_q  <= 1'b0;
      busEn_q     <= 1'b0;
      busAddr_q   <= '0;
      busWrData_q <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      timer_q      <= '0;
      errTimeout_q <= 1'b0;
`endif
    end else begin
      busEn_q     <= 1'b0;
      busAddr_q   <= '0;
      busWrData_q <= '0;
      case (state_q)
        StIdle: begin
          if (cfgStart) begin
            state_q     <= StCfgBrg;
            busEn_q     <= 1'b1;
            busAddr_q   <= AddrBrg;
            busWrData_q <= cfgBaud;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            errTimeout_q <= 1'b0;
`endif
          end
        end
        StCfgBrg: begin
          state_q     <= StCfgCtl;
          busEn_q     <= 1'b1;
          busAddr_q   <= AddrCtl;
          busWrData_q <= CtlEnable;
        end
        StCfgCtl: begin
          state_q <= StReady;
        end
        StReady: begin
          if (cfgStop || stopPend_q) begin
            state_q     <= StCfgOff;
            busEn_q     <= 1'b1;
            busAddr_q   <= AddrCtl;
            busWrData_q <= CtlDisable;
          end else if (!fifoEmpty) begin
            state_q     <= StSend;
            busEn_q     <= 1'b1;
            busAddr_q   <= AddrTxr;
            busWrData_q <= {8'h00, fifoHead};
          end
        end
        StSend: begin
          state_q <= StWait;
          if (cfgStop) begin
            stopPend_q <= 1'b1;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          timer_q <= '0;
`endif
        end
        StWait: begin
          if (cfgStop) begin
            stopPend_q <= 1'b1;
          end
          if (bus.sigTxInt) begin
            state_q <= StReady;
          end
`ifdef UART_TX_SCHED_TIMEOUT_EN
          else if (timer_q == TimeoutLast) begin
            state_q      <= StCfgOff;
            busEn_q      <= 1'b1;
            busAddr_q    <= AddrCtl;
            busWrData_q  <= CtlDisable;
            errTimeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 24'd1;
          end
`endif
        end
        StCfgOff: begin
          state_q    <= StIdle;
          stopPend_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scenario bench for uart_tx_sched: expected bus writes are queued as stimulus
// is applied and checked by a negedge monitor; scenario tasks check timing.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cfgBaud;
  logic        cfgStart;
  logic        cfgStop;
  logic        busy;
  logic [2:0]  fifoCount;
  logic        errTimeout;

  int checks = 0;
  int errors = 0;
  bit monOn  = 1'b0;

  logic [17:0] expQ [$];

  uart_tx_sched_if txIf ();

  uart_tx_sched #(.DEPTH(4), .TIMEOUT(100)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfgBaud    (cfgBaud),
    .cfgStart   (cfgStart),
    .cfgStop    (cfgStop),
    .bus        (txIf),
    .busy       (busy),
    .fifoCount  (fifoCount),
    .errTimeout (errTimeout)
  );

  always #5 clk = ~clk;

  // Every bus write must match the next queued expectation; an idle bus must be all zero.
  always @(negedge clk) begin
    if (monOn) begin
      checks++;
      if (txIf.busEn === 1'b1) begin
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write",
                   txIf.busAddr, txIf.busWrData);
        end else begin
          logic [17:0] exp;
          exp = expQ.pop_front();
          if ({txIf.busWr, txIf.busAddr, txIf.busWrData} !== {1'b1, exp}) begin
            errors++;
            $display("[TB] FAIL bus_write: got wr=%b addr=%0d data=%h, required wr=1 addr=%0d data=%h",
                     txIf.busWr, txIf.busAddr, txIf.busWrData, exp[17:16], exp[15:0]);
          end
        end
      end else if ({txIf.busEn, txIf.busWr, txIf.busAddr, txIf.busWrData} !== 20'h0) begin
        errors++;
        $display("[TB] FAIL bus_idle: got en=%b wr=%b addr=%b data=%h, required all zero",
                 txIf.busEn, txIf.busWr, txIf.busAddr, txIf.busWrData);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitTxr(input int maxCycles, output bit found);
    found = 1'b0;
    for (int i = 0; i < maxCycles && !found; i++) begin
      tick();
      if (txIf.busEn === 1'b1 && txIf.busAddr === 2'd2) found = 1'b1;
    end
  endtask

  task automatic startUart();
    expQ.push_back({2'd0, cfgBaud});
    expQ.push_back({2'd1, 16'h0001});
    cfgStart = 1'b1;
    tick();
    cfgStart = 1'b0;
    tick();
    tick();
  endtask

  task automatic stopUart();
    expQ.push_back({2'd1, 16'h0000});
    cfgStop = 1'b1;
    tick();
    cfgStop = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; cfgBaud = 16'h0010; cfgStart = 1'b0; cfgStop = 1'b0;
    txIf.inValid = 1'b0; txIf.inData = 8'h00; txIf.sigTxInt = 1'b0;
    tick(); tick(); tick();
    monOn = 1'b1;
    checks++;
    if ({txIf.inReady, busy, fifoCount, errTimeout} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got inReady=%b busy=%b count=%0d err=%b, required all 0",
               txIf.inReady, busy, fifoCount, errTimeout);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (txIf.inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: got %b required 1", txIf.inReady);
    end
  endtask

  task automatic test_config();
    expQ.push_back({2'd0, 16'h0010});
    expQ.push_back({2'd1, 16'h0001});
    cfgStart = 1'b1;
    tick();
    cfgStart = 1'b0;
    checks++;
    if ({txIf.busEn, txIf.busAddr, txIf.busWrData} !== {1'b1, 2'd0, 16'h0010}) begin
      errors++;
      $display("[TB] FAIL cfg_brg_cycle: got en=%b addr=%0d data=%h required 1/0/0010",
               txIf.busEn, txIf.busAddr, txIf.busWrData);
    end
    tick();
    checks++;
    if ({txIf.busEn, txIf.busAddr, txIf.busWrData} !== {1'b1, 2'd1, 16'h0001}) begin
      errors++;
      $display("[TB] FAIL cfg_ctl_cycle: got en=%b addr=%0d data=%h required 1/1/0001",
               txIf.busEn, txIf.busAddr, txIf.busWrData);
    end
    tick();
    checks++;
    if ({txIf.busEn, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL cfg_ready: got en=%b busy=%b required 0/0", txIf.busEn, busy);
    end
    cfgStart = 1'b1;
    tick();
    cfgStart = 1'b0;
    checks++;
    if (txIf.busEn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_in_ready_ignored: got en=%b required 0", txIf.busEn);
    end
    stopUart();
    checks++;
    if ({txIf.busEn, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL stop_to_idle: got en=%b busy=%b required 0/0", txIf.busEn, busy);
    end
  endtask

  task automatic test_ignored();
    cfgStop = 1'b1;
    txIf.sigTxInt = 1'b1;
    tick();
    cfgStop = 1'b0;
    txIf.sigTxInt = 1'b0;
    tick();
    checks++;
    if ({txIf.busEn, busy, fifoCount} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL idle_ignores_stop: got en=%b busy=%b count=%0d required 0/0/0",
               txIf.busEn, busy, fifoCount);
    end
  endtask

  task automatic test_idle_push();
    bit found;
    txIf.inValid = 1'b1; txIf.inData = 8'h41;
    tick();
    txIf.inData = 8'h42;
    tick();
    txIf.inValid = 1'b0;
    checks++;
    if ({fifoCount, busy} !== {3'd2, 1'b1}) begin
      errors++;
      $display("[TB] FAIL idle_push_held: got count=%0d busy=%b required 2/1", fifoCount, busy);
    end
    expQ.push_back({2'd0, cfgBaud});
    expQ.push_back({2'd1, 16'h0001});
    expQ.push_back({2'd2, 16'h0041});
    expQ.push_back({2'd2, 16'h0042});
    cfgStart = 1'b1;
    tick();
    cfgStart = 1'b0;
    waitTxr(10, found);
    checks++;
    if (!found || txIf.busWrData !== 16'h0041) begin
      errors++;
      $display("[TB] FAIL first_txr: got found=%b data=%h required 1/0041", found, txIf.busWrData);
    end
    tick(); tick(); tick();
    txIf.sigTxInt = 1'b1;
    tick();
    txIf.sigTxInt = 1'b0;
    checks++;
    if (txIf.busEn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL one_ready_gap: got en=%b required 0", txIf.busEn);
    end
    tick();
    checks++;
    if ({txIf.busEn, txIf.busAddr, txIf.busWrData} !== {1'b1, 2'd2, 16'h0042}) begin
      errors++;
      $display("[TB] FAIL second_txr: got en=%b addr=%0d data=%h required 1/2/0042",
               txIf.busEn, txIf.busAddr, txIf.busWrData);
    end
    tick();
    txIf.sigTxInt = 1'b1;
    tick();
    txIf.sigTxInt = 1'b0;
    stopUart();
  endtask

  task automatic test_backpressure();
    bit found;
    for (int i = 0; i < 4; i++) begin
      txIf.inValid = 1'b1; txIf.inData = 8'h50 + 8'(i);
      tick();
    end
    txIf.inData = 8'h54;
    checks++;
    if ({fifoCount, txIf.inReady} !== {3'd4, 1'b0}) begin
      errors++;
      $display("[TB] FAIL full_not_ready: got count=%0d ready=%b required 4/0", fifoCount, txIf.inReady);
    end
    tick(); tick();
    checks++;
    if (fifoCount !== 3'd4) begin
      errors++;
      $display("[TB] FAIL full_holds: got count=%0d required 4", fifoCount);
    end
    expQ.push_back({2'd0, cfgBaud});
    expQ.push_back({2'd1, 16'h0001});
    expQ.push_back({2'd2, 16'h0050});
    cfgStart = 1'b1;
    tick();
    cfgStart = 1'b0;
    waitTxr(10, found);
    checks++;
    if (!found || {fifoCount, txIf.inReady} !== {3'd4, 1'b0}) begin
      errors++;
      $display("[TB] FAIL send_while_full: got found=%b count=%0d ready=%b required 1/4/0",
               found, fifoCount, txIf.inReady);
    end
    tick();
    checks++;
    if ({fifoCount, txIf.inReady} !== {3'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL after_pop: got count=%0d ready=%b required 3/1", fifoCount, txIf.inReady);
    end
    tick();
    txIf.inValid = 1'b0;
    checks++;
    if (fifoCount !== 3'd4) begin
      errors++;
      $display("[TB] FAIL fifth_accepted: got count=%0d required 4", fifoCount);
    end
    for (int b = 1; b < 5; b++) begin
      expQ.push_back({2'd2, 8'h00, 8'h50 + 8'(b)});
      txIf.sigTxInt = 1'b1;
      tick();
      txIf.sigTxInt = 1'b0;
      tick();
      checks++;
      if ({txIf.busEn, txIf.busWrData} !== {1'b1, 8'h00, 8'h50 + 8'(b)}) begin
        errors++;
        $display("[TB] FAIL drain_txr_%0d: got en=%b data=%h required 1/%h",
                 b, txIf.busEn, txIf.busWrData, 8'h50 + 8'(b));
      end
      tick();
    end
    txIf.sigTxInt = 1'b1;
    tick();
    txIf.sigTxInt = 1'b0;
    checks++;
    if ({busy, fifoCount} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL drained_ready: got busy=%b count=%0d required 0/0", busy, fifoCount);
    end
    stopUart();
  endtask

  task automatic test_stop_in_wait();
    startUart();
    expQ.push_back({2'd2, 16'h0060});
    txIf.inValid = 1'b1; txIf.inData = 8'h60;
    tick();
    txIf.inData = 8'h61;
    tick();
    txIf.inValid = 1'b0;
    checks++;
    if ({txIf.busEn, txIf.busAddr, txIf.busWrData} !== {1'b1, 2'd2, 16'h0060}) begin
      errors++;
      $display("[TB] FAIL stop_txr: got en=%b addr=%0d data=%h required 1/2/0060",
               txIf.busEn, txIf.busAddr, txIf.busWrData);
    end
    tick();
    cfgStop = 1'b1;
    tick();
    cfgStop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (txIf.busEn !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stop_deferred_%0d: got en=%b required 0", i, txIf.busEn);
      end
    end
    expQ.push_back({2'd1, 16'h0000});
    txIf.sigTxInt = 1'b1;
    tick();
    txIf.sigTxInt = 1'b0;
    tick();
    checks++;
    if ({txIf.busEn, txIf.busAddr, txIf.busWrData} !== {1'b1, 2'd1, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL stop_ctl_off: got en=%b addr=%0d data=%h required 1/1/0000",
               txIf.busEn, txIf.busAddr, txIf.busWrData);
    end
    tick();
    checks++;
    if ({fifoCount, busy} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL stop_flush_idle: got count=%0d busy=%b required 0/0", fifoCount, busy);
    end
  endtask

`ifdef UART_TX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit found;
    int n;
    startUart();
    expQ.push_back({2'd2, 16'h0070});
    txIf.inValid = 1'b1; txIf.inData = 8'h70;
    tick();
    txIf.inData = 8'h71;
    tick();
    txIf.inValid = 1'b0;
    checks++;
    if (txIf.busEn !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_txr: got en=%b required 1", txIf.busEn);
    end
    tick();
    expQ.push_back({2'd1, 16'h0000});
    n = 0;
    while (txIf.busEn !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 100 || errTimeout !== 1'b1 || txIf.busAddr !== 2'd1) begin
      errors++;
      $display("[TB] FAIL timeout_fire: got cycles=%0d err=%b addr=%0d required 100/1/1",
               n, errTimeout, txIf.busAddr);
    end
    tick();
    checks++;
    if ({fifoCount, busy, errTimeout} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL timeout_idle: got count=%0d busy=%b err=%b required 0/0/1",
               fifoCount, busy, errTimeout);
    end
    startUart();
    checks++;
    if (errTimeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got err=%b required 0", errTimeout);
    end
    stopUart();
  endtask
`endif

  task automatic test_reset_mid();
    startUart();
    expQ.push_back({2'd2, 16'h0080});
    for (int i = 0; i < 4; i++) begin
      txIf.inValid = 1'b1; txIf.inData = 8'h80 + 8'(i);
      tick();
    end
    txIf.inValid = 1'b0;
    checks++;
    if ({fifoCount, busy} !== {3'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mid_queue: got count=%0d busy=%b required 3/1", fifoCount, busy);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if ({txIf.busEn, txIf.busWr, txIf.busAddr, txIf.busWrData, txIf.inReady, busy, fifoCount, errTimeout}
        !== 26'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got en=%b ready=%b busy=%b count=%0d err=%b required all 0",
               txIf.busEn, txIf.inReady, busy, fifoCount, errTimeout);
    end
    txIf.sigTxInt = 1'b1;
    tick();
    txIf.sigTxInt = 1'b0;
    rstn = 1'b1;
    #1;
    checks++;
    if (txIf.inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_release_ready: got %b required 1", txIf.inReady);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({txIf.busEn, busy} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL mid_no_write_%0d: got en=%b busy=%b required 0/0", i, txIf.busEn, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_ignored();
    test_idle_push();
    test_backpressure();
    test_stop_in_wait();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_writes: got %0d outstanding required 0", expQ.size());
    end
    monOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning TX byte FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 720896, meaning the cycle limit while waiting for TX completion (24-bit).
REQ-003 The block SHALL have port clk  in  1  single system clock, all state on rising edge.
REQ-004 The block SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port cfgBaud  in  16  baud divisor, written to UART BRG.
REQ-006 The block SHALL have port cfgStart  in  1  pulse; configure and enable the UART.
REQ-007 The block SHALL have port cfgStop  in  1  pulse; disable the UART and flush the FIFO.
REQ-008 The block SHALL have port inValid  in  1  requester byte valid.
REQ-009 The block SHALL have port inData  in  8  requester byte.
REQ-010 The block SHALL have port inReady  out  1  FIFO can accept a byte.
REQ-011 The block SHALL have port busEn  out  1  UART bus enable.
REQ-012 The block SHALL have port busWr  out  1  UART bus write (always 1 when busEn=1).
REQ-013 The block SHALL have port busAddr  out  2  UART register: 0 BRG, 1 CTL, 2 TXR.
REQ-014 The block SHALL have port busWrData  out  16  write data to the UART data line.
REQ-015 The block SHALL have port sigTxInt  in  1  UART TX-done pulse.
REQ-016 The block SHALL have port busy  out  1  state is not IDLE or READY, or the FIFO is non-empty.
REQ-017 The block SHALL have port fifoCount  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-018 The block SHALL have port errTimeout  out  1  sticky timeout flag (macro-dependent).

Function
REQ-019 The FSM SHALL have states IDLE, CFG_BRG, CFG_CTL, READY, SEND, WAIT and CFG_OFF.
REQ-020 In IDLE, cfgStart SHALL go to CFG_BRG; CFG_BRG SHALL drive busEn=1, busAddr=0, busWrData=cfgBaud for one cycle, then go to CFG_CTL.
REQ-021 CFG_CTL SHALL drive busEn=1, busAddr=1, busWrData=16'h0001 for one cycle, then go to READY.
REQ-022 In READY with the FIFO non-empty and no cfgStop, the FSM SHALL go to SEND.
REQ-023 SEND SHALL drive busEn=1, busAddr=2, busWrData={8'h00, FIFO head} for exactly one cycle, pop the head in that cycle, then go to WAIT.
REQ-024 WAIT SHALL hold busEn=0 until sigTxInt=1, then go to READY; back-to-back bytes are separated by exactly one READY cycle.
REQ-025 When busEn=0, busWr, busAddr and busWrData SHALL be 0.
REQ-026 cfgStop in READY SHALL go to CFG_OFF; CFG_OFF SHALL write CTL=16'h0000 for one cycle, flush the FIFO, then go to IDLE.
REQ-027 cfgStop in SEND or WAIT SHALL be latched and acted on at the next READY entry, so the in-flight byte completes.
REQ-028 cfgStop in IDLE, and cfgStart outside IDLE, SHALL be ignored.
REQ-029 FIFO push SHALL occur when inValid & inReady; inReady = (fifoCount != DEPTH) and state != CFG_OFF.
REQ-030 Simultaneous push and pop SHALL leave fifoCount unchanged.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 Pushes while in IDLE SHALL be accepted and held until the UART is configured.
REQ-033 sigTxInt outside WAIT SHALL be ignored.

Reset
REQ-034 While rstn=0 at a clock edge: state=IDLE, FIFO empty, fifoCount=0, inReady=0, busEn=busWr=0, busAddr=0, busWrData=0, busy=0, errTimeout=0, stop latch=0, timeout counter=0.
REQ-035 Reset mid-transfer SHALL abandon the transfer without a bus write; inReady SHALL be 1 from the first cycle after reset release.

Configuration
REQ-036 With UART_TX_SCHED_TIMEOUT_EN defined: a 24-bit counter clears on WAIT entry and increments each WAIT cycle; on reaching TIMEOUT the FSM SHALL go to CFG_OFF, set errTimeout (cleared only by cfgStart or reset) and flush the FIFO.
REQ-037 Without UART_TX_SCHED_TIMEOUT_EN: no counter, WAIT waits indefinitely, and errTimeout is tied to 0.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, the register address constants (BRG=0, CTL=1, TXR=2) and the CTL enable value.
REQ-039 The FIFO SHALL be a sub-module, uart_tx_fifo (DEPTH x 8, push/pop/count/full/empty).

Verification
REQ-040 Reset, then cfgBaud=16'h0010 and a cfgStart pulse -> write BRG=0x0010 on cycle +1 and CTL=0x0001 on cycle +2, then READY.
REQ-041 Push 0x41,0x42 while in IDLE, then cfgStart -> TXR writes 0x0041 then 0x0042, each issued one READY cycle after the prior sigTxInt pulse.
REQ-042 Push 5 bytes back-to-back with DEPTH=4 and no sigTxInt -> inReady=0 at fifoCount=4; the 5th byte is accepted only after the first pop.
REQ-043 cfgStop during WAIT -> no CTL write until sigTxInt; then CTL=0x0000 and IDLE with fifoCount=0.
REQ-044 With the macro defined and TIMEOUT=100, withhold sigTxInt -> after 100 WAIT cycles CTL=0x0000 is written, errTimeout=1, then IDLE.
REQ-045 Assert rstn=0 during WAIT with 3 bytes queued -> all outputs at reset values next cycle and no further bus writes.
